bfm_apbslave_ram: RTL and testbench

APB3 completer model with internal word RAM, programmable wait states and completion counting. It sits directly downstream of the APB-to-APB bridge BFM and consumes one bit of its PSEL vector plus the shared PADDR/PWRITE/PENABLE/PWDATA. It returns PRDATA/PREADY/PSLVERR to the bridge, which exercises the bridge's wait and error paths in simulation.

---
 rtl/bfm_apbslave_ram.sv | 164 ++++++++++++++++
 tb/tb_bfm_apbslave_ram.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bfm_apbslave_ram.sv
// APB3 completer BFM: word RAM, programmable wait states, completion counter.
// Optional out-of-range error response enabled by defining APBSLV_RANGE_ERR_EN.
module bfm_apbslave_ram #(
  parameter int AWIDTH      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] XFER_CNT
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [31:0]       r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_idx, w_idx_nxt;
  logic              r_oor, w_oor_nxt;
  logic              r_write, w_write_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [31:0]       r_prdata, w_prdata_nxt;
  logic              r_pready, w_pready_nxt;
  logic              r_pslverr, w_pslverr_nxt;
  logic [15:0]       r_xfer_cnt, w_xfer_cnt_nxt;

  logic              w_paddr_oor;
  logic              w_load;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_src_idx;
  logic              w_src_oor;
  logic              w_src_write;
  logic              w_unused_paddr;

`ifdef APBSLV_RANGE_ERR_EN
  assign w_paddr_oor    = |PADDR[31:AWIDTH+2];
  assign w_unused_paddr = ^PADDR[1:0];
`else
  assign w_paddr_oor    = 1'b0;
  assign w_unused_paddr = ^{PADDR[31:AWIDTH+2], PADDR[1:0]};
`endif

  // Zero-wait transfers load the response on the setup edge, before the
  // address registers hold the new transfer, so take it from the bus there.
  assign w_src_idx   = (r_state == IDLE) ? PADDR[AWIDTH+1:2] : r_idx;
  assign w_src_oor   = (r_state == IDLE) ? w_paddr_oor       : r_oor;
  assign w_src_write = (r_state == IDLE) ? PWRITE            : r_write;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_oor      <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_oor      <= w_oor_nxt;
      r_write    <= w_write_nxt;
      r_wdata    <= w_wdata_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prdata   <= w_prdata_nxt;
      r_pready   <= w_pready_nxt;
      r_pslverr  <= w_pslverr_nxt;
      r_xfer_cnt <= w_xfer_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_oor_nxt      = r_oor;
    w_write_nxt    = r_write;
    w_wdata_nxt    = r_wdata;
    w_cnt_nxt      = r_cnt;
    w_prdata_nxt   = r_prdata;
    w_pready_nxt   = r_pready;
    w_pslverr_nxt  = r_pslverr;
    w_xfer_cnt_nxt = r_xfer_cnt;
    w_load         = 1'b0;
    w_mem_we       = 1'b0;

    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_idx_nxt   = PADDR[AWIDTH+1:2];
          w_oor_nxt   = w_paddr_oor;
          w_write_nxt = PWRITE;
          w_wdata_nxt = PWDATA;
          w_cnt_nxt   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_nxt = DONE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt   = IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = DONE;
            w_load      = 1'b1;
          end
        end
      end
      DONE: begin
        if (!PSEL) begin
          w_state_nxt   = IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (PENABLE && r_pready) begin
          w_mem_we       = r_write && !r_pslverr;
          w_xfer_cnt_nxt = r_xfer_cnt + 16'd1;
          w_pready_nxt   = 1'b0;
          w_pslverr_nxt  = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_pready_nxt  = 1'b1;
      w_pslverr_nxt = w_src_oor;
      if (!w_src_write) begin
        w_prdata_nxt = w_src_oor ? '0 : r_mem[w_src_idx];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign XFER_CNT = r_xfer_cnt;

endmodule

// File: tb/tb_bfm_apbslave_ram.sv
// Directed bench for bfm_apbslave_ram: three instances (0, 3, 5 wait states) on a shared bus.
module tb_bfm_apbslave_ram;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  psel;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [15:0] cnt [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_rd [3];
  int          ws [3];

  bfm_apbslave_ram #(.AWIDTH(10), .WAIT_STATES(0)) u_w0 (
    .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .XFER_CNT(cnt[0]));

  bfm_apbslave_ram #(.AWIDTH(10), .WAIT_STATES(3)) u_w3 (
    .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .XFER_CNT(cnt[1]));

  bfm_apbslave_ram #(.AWIDTH(10), .WAIT_STATES(5)) u_w5 (
    .PCLK(clk), .PRESET(rst[2]), .PSEL(psel[2]), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .XFER_CNT(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   waits;
    bit   got;
    @(posedge clk); #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    if (!wr) last_rd[d] = exp_rd;
    e.rd    = last_rd[d];
    e.err   = exp_err;
    e.waits = ws[d];
    q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    chk($sformatf("pready_seen[%0d]@%h", d, addr), 32'(got), 32'd1);
    e = q.pop_front();
    if (got) begin
      chk($sformatf("prdata[%0d]@%h", d, addr), prdata[d], e.rd);
      chk($sformatf("pslverr[%0d]@%h", d, addr), 32'(pslverr[d]), 32'(e.err));
      chk($sformatf("wait_cycles[%0d]@%h", d, addr), 32'(waits), 32'(e.waits));
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic exp_err;
    ws[0] = 0; ws[1] = 3; ws[2] = 5;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    rst = '1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_prdata[%0d]", i), prdata[i], 32'd0);
      chk($sformatf("rst_pready[%0d]", i), 32'(pready[i]), 32'd0);
      chk($sformatf("rst_pslverr[%0d]", i), 32'(pslverr[i]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", i), 32'(cnt[i]), 32'd0);
    end

    // zero wait states
    xfer(0, 1'b1, 32'h004, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h004, 32'h0, 32'hDEADBEEF, 1'b0);
    bus_idle();
    chk("cnt_w0_basic", 32'(cnt[0]), 32'd2);

    // three wait states
    xfer(1, 1'b1, 32'h008, 32'h12345678, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h008, 32'h0, 32'h12345678, 1'b0);
    bus_idle();
    chk("cnt_w3_basic", 32'(cnt[1]), 32'd2);

    // back-to-back writes then reads, no idle cycles between
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'(i * 4), 32'(i + 1), 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0, 32'(i + 1), 1'b0);
    bus_idle();
    chk("cnt_w0_b2b", 32'(cnt[0]), 32'd10);

    // address above the RAM window
`ifdef APBSLV_RANGE_ERR_EN
    exp_err = 1'b1;
    xfer(0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0, exp_err);
    xfer(0, 1'b0, 32'h1000, 32'h0, 32'h0, exp_err);
    xfer(0, 1'b0, 32'h0000, 32'h0, 32'h1, 1'b0);
`else
    exp_err = 1'b0;
    xfer(0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0, exp_err);
    xfer(0, 1'b0, 32'h1000, 32'h0, 32'hA5A5A5A5, exp_err);
    xfer(0, 1'b0, 32'h0000, 32'h0, 32'hA5A5A5A5, 1'b0);
`endif
    bus_idle();
    chk("cnt_w0_range", 32'(cnt[0]), 32'd13);

    // PENABLE without setup while idle
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h004; pwdata = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("penable_only_pready", 32'(pready[0]), 32'd0);
    end
    bus_idle();
    chk("cnt_penable_only", 32'(cnt[0]), 32'd13);
    xfer(0, 1'b0, 32'h004, 32'h0, 32'h2, 1'b0);
    bus_idle();

    // abort by dropping PSEL during wait states
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h008; pwdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_pready_wait", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pready_after", 32'(pready[1]), 32'd0);
    chk("abort_cnt", 32'(cnt[1]), 32'd2);
    xfer(1, 1'b0, 32'h008, 32'h0, 32'h12345678, 1'b0);
    bus_idle();
    chk("cnt_after_abort", 32'(cnt[1]), 32'd3);

    // asynchronous reset in the middle of a write with five wait states
    xfer(2, 1'b1, 32'h010, 32'h11112222, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h010, 32'h0, 32'h11112222, 1'b0);
    bus_idle();
    chk("cnt_w5_pre", 32'(cnt[2]), 32'd2);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h99999999;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst[2] = 1'b1;
    #1;
    chk("midrst_prdata", prdata[2], 32'd0);
    chk("midrst_pready", 32'(pready[2]), 32'd0);
    chk("midrst_pslverr", 32'(pslverr[2]), 32'd0);
    chk("midrst_cnt", 32'(cnt[2]), 32'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    last_rd[2] = '0;
    xfer(2, 1'b0, 32'h010, 32'h0, 32'h11112222, 1'b0);
    bus_idle();
    chk("cnt_w5_post", 32'(cnt[2]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
